rs_mem: RTL and testbench
=========================

Name: rs_mem

Overview:
- Load reservation station sitting directly upstream of fu_mem.
- Accepts dispatched LOAD instructions and holds them until the base-address physical register (ps1) is ready.
- Wakes entries on the CDB broadcast and issues the oldest ready load to fu_mem, one per cycle, only while fu_mem reports ready.
- Flushes entries younger than a mispredicted branch.

Parameters:
- DEPTH, 8, number of RS entries (power of two, 2..16).
- ROB_W, 5, ROB index width; must match rs_data.rob_index.
- PREG_W, 7, physical register tag width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (reset==0 resets the block on the clk rising edge).
- disp_valid  in  1  dispatch request.
- disp_data  in  rs_data  dispatched instruction; Opcode is always 7'b0000011.
- disp_ps1_ready  in  1  ps1 already available at dispatch.
- rs_full  out  1  no free entry; dispatch must not be asserted while high.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_tag  in  PREG_W  physical register being written back.
- fu_mem_ready  in  1  fu_mem can accept an issue this cycle.
- issued  out  1  one-cycle issue pulse to fu_mem.
- issue_data  out  rs_data  issued instruction; stable while issued=1.
- mispredict  in  1  branch mispredict flush.
- mispredict_tag  in  ROB_W  ROB index of the mispredicted branch.
- curr_rob_tag  in  ROB_W  ROB tail (next allocation index).

Behaviour:
- Entry contents: valid, rs_data, ps1_ready, age (log2(DEPTH)+1 bits).
- Reset (reset==0 at posedge): all entries invalid, ages 0, issued=0, issue_data='0, rs_full=0.
- Dispatch: disp_valid && !rs_full writes the lowest-index free entry.
  - ps1_ready = disp_ps1_ready | (cdb_valid && cdb_tag==disp_data.ps1).
  - age = 0; all other valid entries increment age (saturating at DEPTH).
- Wakeup: each valid entry with cdb_valid && cdb_tag==ps1 sets ps1_ready at the next edge.
- Select/issue (registered, 1-cycle latency):
  - Among entries that are valid and ps1_ready at the start of the cycle, with fu_mem_ready=1, pick the maximum age; ties go to the lowest index.
  - Next edge: issued=1, issue_data=entry, entry invalidated.
  - Otherwise issued=0; issue_data holds its last value.
  - At most one issue per cycle.
  - An entry woken this cycle is eligible next cycle, not this cycle.
- rs_full = (count of valid entries == DEPTH), computed combinationally from registered state.
- Simultaneous issue and dispatch: the freed slot is usable only in the next cycle. rs_full does not anticipate the issue.
- Mispredict (level):
  - Invalidate every entry whose rob_index lies in the circular open interval (mispredict_tag, curr_rob_tag), using the wrap-around distance ((idx - mispredict_tag) mod 2^ROB_W) < ((curr_rob_tag - mispredict_tag) mod 2^ROB_W), idx != mispredict_tag.
  - A dispatch in the same cycle is dropped.
  - If the selected candidate is flushed, issued=0 next cycle.
  - The mispredict_tag entry itself survives.
- Empty RS: issued stays 0; no age updates.
- Reset mid-operation clears everything regardless of in-progress wakeup, dispatch, or issue.

Optional Feature:
- Macro: RS_MEM_DISPATCH_BYPASS_EN.
- When defined:
  - If the RS holds no ready entry, fu_mem_ready=1, and a dispatch arrives with effective ps1_ready=1, the instruction is issued at the next edge directly. issued=1, issue_data=disp_data, and no entry is allocated.
  - Mispredict still drops it.
- When undefined: such an instruction is allocated and issues no earlier than one cycle later (2-cycle dispatch-to-issue minimum).

Decomposition:
- types_pkg gains:
  - rs_mem_entry struct (valid, ps1_ready, age, rs_data).
  - LOAD_OPCODE constant 7'b0000011.
  - rob_younger(idx, mispredict_tag, curr_rob_tag) function, shared with fu_mem and the other RSs.
- One sub-module: rs_age_select, a combinational max-age/lowest-index picker over DEPTH request vectors, returning grant index and grant valid.

Test Plan:
- Reset, then dispatch 1 load with ps1_ready=1 and fu_mem_ready=1 → issued pulses 1 cycle later (2 without bypass macro) with issue_data.rob_index=1; rs_full stays 0.
- Dispatch loads rob 2 (ps1=20, not ready) and rob 3 (ready), fu_mem_ready=1 → rob 3 issues first. CDB tag 20 → rob 2 issues exactly 2 cycles after the broadcast.
- Fill 8 entries with unready ps1 → rs_full=1 after the 8th. A 9th disp_valid is a bench assertion error. One wakeup plus issue → rs_full=0 the cycle after the issue.
- Entries rob 4,5,6,7 unready; mispredict_tag=3, curr_rob_tag=6 → entries 4,5 invalidated, 6,7 retained. Wrap case: mispredict_tag=30, curr_rob_tag=2 flushes 31,0,1.
- fu_mem_ready=0 with 3 ready entries → no issue. Release ready → issues in dispatch order (oldest first), one per cycle.
- Assert reset=0 while 4 entries are valid and an issue is pending → next cycle all invalid, issued=0, issue_data=0, rs_full=0.

Source files
------------

// File: rtl/rs_mem_pkg.sv
// rs_mem_pkg: shared load-RS types, the load opcode and the ROB age-ordering helper.
package rs_mem_pkg;
    localparam int RS_ROB_W  = 5;
    localparam int RS_PREG_W = 7;
    // wide enough for ages up to DEPTH=16
    localparam int RS_AGE_W  = 5;
    localparam logic [6:0] LOAD_OPCODE = 7'b0000011;
    typedef struct packed {
        logic [6:0]           opcode;
        logic [RS_ROB_W-1:0]  rob_index;
        logic [RS_PREG_W-1:0] ps1;
        logic [RS_PREG_W-1:0] pd;
        logic [11:0]          imm;
    } rs_data;
    typedef struct packed {
        logic                valid;
        logic                ps1_ready;
        logic [RS_AGE_W-1:0] age;
        rs_data              data;
    } rs_mem_entry;
    function automatic logic rob_younger(
        input logic [RS_ROB_W-1:0] idx,
        input logic [RS_ROB_W-1:0] mispredict_tag,
        input logic [RS_ROB_W-1:0] curr_rob_tag
    );
        logic [RS_ROB_W-1:0] d_idx;
        logic [RS_ROB_W-1:0] d_tail;
        d_idx  = idx - mispredict_tag;
        d_tail = curr_rob_tag - mispredict_tag;
        return (idx != mispredict_tag) && (d_idx < d_tail);
    endfunction
endpackage

// File: rtl/rs_age_select.sv
// rs_age_select: combinational picker granting the oldest requester, lowest index on ties.
module rs_age_select #(
    parameter int N  = 8,
    parameter int AW = 5,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0][AW-1:0] age,
    output logic [IW-1:0]        gnt_idx,
    output logic                 gnt_valid
);
    logic [AW-1:0] best;
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        best      = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (!gnt_valid || age[i] > best)) begin
                gnt_idx   = IW'(i);
                gnt_valid = 1'b1;
                best      = age[i];
            end
        end
    end
endmodule

// File: rtl/rs_mem.sv
// rs_mem: load reservation station feeding fu_mem with CDB wakeup, oldest-first issue and mispredict flush.
// Optional RS_MEM_DISPATCH_BYPASS_EN issues a ready dispatch straight to fu_mem when nothing else is ready.
module rs_mem
    import rs_mem_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int ROB_W  = RS_ROB_W,
    parameter int PREG_W = RS_PREG_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              disp_valid,
    input  rs_data            disp_data,
    input  logic              disp_ps1_ready,
    output logic              rs_full,
    input  logic              cdb_valid,
    input  logic [PREG_W-1:0] cdb_tag,
    input  logic              fu_mem_ready,
    output logic              issued,
    output rs_data            issue_data,
    input  logic              mispredict,
    input  logic [ROB_W-1:0]  mispredict_tag,
    input  logic [ROB_W-1:0]  curr_rob_tag
);
    localparam int IW = $clog2(DEPTH);
    rs_mem_entry ent [DEPTH];
    rs_mem_entry ent_nxt [DEPTH];
    logic [DEPTH-1:0] valid_vec;
    logic [DEPTH-1:0] ready_vec;
    logic [DEPTH-1:0] flush;
    logic [DEPTH-1:0][RS_AGE_W-1:0] ages;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] free_idx;
    logic gnt_valid;
    logic disp_go;
    logic disp_rdy;
    logic bypass;
    logic alloc;
    logic issue_ok;
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent[i].valid;
            ready_vec[i] = ent[i].valid && ent[i].ps1_ready;
            flush[i]     = mispredict && ent[i].valid
                           && rob_younger(ent[i].data.rob_index, mispredict_tag, curr_rob_tag);
            ages[i]      = ent[i].age;
        end
    end
    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--)
            if (!ent[i].valid) free_idx = IW'(i);
    end
    rs_age_select #(.N(DEPTH), .AW(RS_AGE_W)) u_sel (
        .req       (ready_vec & {DEPTH{fu_mem_ready}}),
        .age       (ages),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );
    assign rs_full  = &valid_vec;
    assign disp_go  = disp_valid && !rs_full && !mispredict;
    assign disp_rdy = disp_ps1_ready || (cdb_valid && cdb_tag == disp_data.ps1);
    assign issue_ok = gnt_valid && !flush[gnt_idx];
`ifdef RS_MEM_DISPATCH_BYPASS_EN
    assign bypass = disp_go && disp_rdy && fu_mem_ready && !(|ready_vec);
`else
    assign bypass = 1'b0;
`endif
    assign alloc = disp_go && !bypass;
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_nxt[i] = ent[i];
            if (ent[i].valid && cdb_valid && cdb_tag == ent[i].data.ps1)
                ent_nxt[i].ps1_ready = 1'b1;
            if (alloc && ent[i].valid && ent[i].age != RS_AGE_W'(DEPTH))
                ent_nxt[i].age = ent[i].age + 1'b1;
            // a granted entry leaves even if flushed; the flush only suppresses the issue pulse
            if (flush[i] || (gnt_valid && gnt_idx == IW'(i)))
                ent_nxt[i].valid = 1'b0;
            if (alloc && free_idx == IW'(i))
                ent_nxt[i] = '{valid: 1'b1, ps1_ready: disp_rdy, age: '0, data: disp_data};
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            issued     <= 1'b0;
            issue_data <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= ent_nxt[i];
            issued <= issue_ok || bypass;
            if (bypass)
                issue_data <= disp_data;
            else if (issue_ok)
                issue_data <= ent[gnt_idx].data;
        end
    end
endmodule

// File: tb/tb_rs_mem.sv
// tb_rs_mem: directed and randomized checks of rs_mem against a slot-level behavioural model.
module tb_rs_mem;
    import rs_mem_pkg::*;
    localparam int DEPTH = 8;
`ifdef RS_MEM_DISPATCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset;
    logic disp_valid;
    rs_data disp_data;
    logic disp_ps1_ready;
    logic rs_full;
    logic cdb_valid;
    logic [RS_PREG_W-1:0] cdb_tag;
    logic fu_mem_ready;
    logic issued;
    rs_data issue_data;
    logic mispredict;
    logic [RS_ROB_W-1:0] mispredict_tag;
    logic [RS_ROB_W-1:0] curr_rob_tag;

    rs_mem #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .disp_valid(disp_valid), .disp_data(disp_data),
        .disp_ps1_ready(disp_ps1_ready), .rs_full(rs_full), .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag), .fu_mem_ready(fu_mem_ready), .issued(issued),
        .issue_data(issue_data), .mispredict(mispredict), .mispredict_tag(mispredict_tag),
        .curr_rob_tag(curr_rob_tag)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int iss_q[$];

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: slots with dispatch sequence numbers; age = later allocations, capped
    bit     m_valid [DEPTH];
    bit     m_rdy   [DEPTH];
    rs_data m_data  [DEPTH];
    int     m_seq   [DEPTH];
    int     alloc_cnt = 0;
    bit     exp_issued = 0;
    rs_data exp_data = '0;
    bit     exp_full = 0;

    function automatic int age_of(int i);
        int a = alloc_cnt - m_seq[i] - 1;
        return a > DEPTH ? DEPTH : a;
    endfunction

    function automatic bit younger(int idx);
        int d_i = (idx - int'(mispredict_tag)) & 31;
        int d_t = (int'(curr_rob_tag) - int'(mispredict_tag)) & 31;
        return mispredict && idx != int'(mispredict_tag) && d_i < d_t;
    endfunction

    function automatic bit model_full();
        foreach (m_valid[i]) if (!m_valid[i]) return 0;
        return 1;
    endfunction

    always @(posedge clk) begin
        int pick;
        int best;
        int fr;
        bit any_rdy;
        bit go;
        bit erdy;
        bit byp;
        if (!reset) begin
            foreach (m_valid[i]) m_valid[i] = 0;
            exp_issued = 0;
            exp_data = '0;
        end else begin
            pick = -1;
            best = -1;
            any_rdy = 0;
            fr = -1;
            foreach (m_valid[i]) begin
                if (m_valid[i] && m_rdy[i]) begin
                    any_rdy = 1;
                    if (fu_mem_ready && age_of(i) > best) begin
                        best = age_of(i);
                        pick = i;
                    end
                end
                if (!m_valid[i] && fr < 0) fr = i;
            end
            go   = disp_valid && !model_full() && !mispredict;
            erdy = disp_ps1_ready || (cdb_valid && cdb_tag == disp_data.ps1);
            byp  = BYP && go && erdy && fu_mem_ready && !any_rdy;
            exp_issued = 0;
            if (pick >= 0 && !younger(int'(m_data[pick].rob_index))) begin
                exp_issued = 1;
                exp_data = m_data[pick];
            end
            if (byp) begin
                exp_issued = 1;
                exp_data = disp_data;
            end
            foreach (m_valid[i]) begin
                if (m_valid[i] && cdb_valid && cdb_tag == m_data[i].ps1) m_rdy[i] = 1;
                if (m_valid[i] && younger(int'(m_data[i].rob_index))) m_valid[i] = 0;
            end
            if (pick >= 0) m_valid[pick] = 0;
            if (go && !byp) begin
                m_valid[fr] = 1;
                m_rdy[fr] = erdy;
                m_data[fr] = disp_data;
                m_seq[fr] = alloc_cnt;
                alloc_cnt++;
            end
        end
        exp_full = model_full();
    end

    always @(negedge clk) begin
        check("issued", 64'(issued), 64'(exp_issued));
        check("issue_data", 64'(issue_data), 64'(exp_data));
        check("rs_full", 64'(rs_full), 64'(exp_full));
    end

    always @(posedge clk)
        if (reset && disp_valid && rs_full) begin
            n_tests++;
            n_fail++;
            $display("FAIL disp_while_full: disp_valid=1 with rs_full=1 at %0t", $time);
        end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (issued) iss_q.push_back(int'(issue_data.rob_index));
    endtask

    task automatic idle_inputs();
        disp_valid = 0;
        disp_ps1_ready = 0;
        cdb_valid = 0;
        mispredict = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 0;
        tick();
        tick();
        reset = 1;
        iss_q.delete();
    endtask

    task automatic set_data(int rob, int ps1);
        disp_data.opcode = LOAD_OPCODE;
        disp_data.rob_index = RS_ROB_W'(rob);
        disp_data.ps1 = RS_PREG_W'(ps1);
        disp_data.pd = RS_PREG_W'($urandom_range(0, 127));
        disp_data.imm = 12'($urandom_range(0, 4095));
    endtask

    task automatic disp(int rob, int ps1, bit rdy);
        disp_valid = 1;
        set_data(rob, ps1);
        disp_ps1_ready = rdy;
        tick();
        disp_valid = 0;
        disp_ps1_ready = 0;
    endtask

    task automatic wake(int tag);
        cdb_valid = 1;
        cdb_tag = RS_PREG_W'(tag);
        tick();
        cdb_valid = 0;
    endtask

    task automatic wait_issue(string name, int rob, int n);
        int c = 0;
        while (!issued && c < 20) begin
            tick();
            c++;
        end
        check({name, "_latency"}, 64'(c), 64'(n));
        check({name, "_rob"}, 64'(issue_data.rob_index), 64'(rob));
    endtask

    task automatic flush_test(string name, int robs[], int mtag, int ctag, int exp_a, int exp_b);
        do_reset();
        fu_mem_ready = 0;
        foreach (robs[i]) disp(robs[i], 50 + i, 0);
        mispredict = 1;
        mispredict_tag = RS_ROB_W'(mtag);
        curr_rob_tag = RS_ROB_W'(ctag);
        tick();
        mispredict = 0;
        fu_mem_ready = 1;
        iss_q.delete();
        foreach (robs[i]) wake(50 + i);
        repeat (4) tick();
        check({name, "_count"}, 64'(iss_q.size()), 64'd2);
        check({name, "_first"}, 64'(iss_q[0]), 64'(exp_a));
        check({name, "_second"}, 64'(iss_q[1]), 64'(exp_b));
    endtask

    initial begin
        idle_inputs();
        reset = 0;
        cdb_tag = '0;
        fu_mem_ready = 0;
        mispredict_tag = '0;
        curr_rob_tag = '0;
        disp_data = '0;
        do_reset();
        check("reset_issued", 64'(issued), 64'd0);
        check("reset_data", 64'(issue_data), 64'd0);
        check("reset_full", 64'(rs_full), 64'd0);

        // single ready load
        fu_mem_ready = 1;
        disp(1, 5, 1);
        wait_issue("t1", 1, BYP ? 0 : 1);
        check("t1_full", 64'(rs_full), 64'd0);

        // ready load overtakes an older unready one; CDB wakeup issues two cycles later
        do_reset();
        fu_mem_ready = 1;
        disp(2, 20, 0);
        disp(3, 21, 1);
        wait_issue("t2_ready", 3, BYP ? 0 : 1);
        wake(20);
        check("t2_not_yet", 64'(issued), 64'd0);
        wait_issue("t2_woken", 2, 1);

        // fill, then free one slot through wakeup and issue
        do_reset();
        fu_mem_ready = 1;
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("t3_not_full", 64'(rs_full), 64'd0);
            disp(10 + i, 40 + i, 0);
        end
        check("t3_full", 64'(rs_full), 64'd1);
        wake(43);
        check("t3_still_full", 64'(rs_full), 64'd1);
        wait_issue("t3_issue", 13, 1);
        check("t3_full_after_issue", 64'(rs_full), 64'd0);

        flush_test("t4_flush", '{4, 5, 6, 7}, 3, 6, 6, 7);
        flush_test("t4_wrap", '{30, 31, 0, 1, 2}, 30, 2, 30, 2);

        // blocked by fu_mem, then drained oldest first
        do_reset();
        fu_mem_ready = 0;
        disp(10, 1, 1);
        disp(11, 2, 1);
        disp(12, 3, 1);
        repeat (3) tick();
        check("t5_blocked", 64'(iss_q.size()), 64'd0);
        fu_mem_ready = 1;
        repeat (4) tick();
        check("t5_count", 64'(iss_q.size()), 64'd3);
        check("t5_first", 64'(iss_q[0]), 64'd10);
        check("t5_second", 64'(iss_q[1]), 64'd11);
        check("t5_third", 64'(iss_q[2]), 64'd12);

        // reset while entries are valid and an issue is pending
        do_reset();
        fu_mem_ready = 0;
        for (int i = 0; i < 5; i++) disp(20 + i, 60 + i, 1);
        fu_mem_ready = 1;
        tick();
        check("t6_pre_issue", 64'(issue_data.rob_index), 64'd20);
        reset = 0;
        tick();
        check("t6_issued", 64'(issued), 64'd0);
        check("t6_data", 64'(issue_data), 64'd0);
        check("t6_full", 64'(rs_full), 64'd0);
        reset = 1;
        iss_q.delete();
        repeat (3) tick();
        check("t6_empty", 64'(iss_q.size()), 64'd0);

        // randomized traffic, checked every cycle by the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            fu_mem_ready = ($urandom_range(0, 9) < 7);
            cdb_valid = $urandom_range(0, 1);
            cdb_tag = RS_PREG_W'($urandom_range(0, 7));
            mispredict = ($urandom_range(0, 19) == 0);
            mispredict_tag = RS_ROB_W'($urandom_range(0, 31));
            curr_rob_tag = RS_ROB_W'($urandom_range(0, 31));
            disp_valid = !model_full() && $urandom_range(0, 1);
            disp_ps1_ready = ($urandom_range(0, 9) < 3);
            set_data($urandom_range(0, 31), $urandom_range(0, 7));
            tick();
        end
        idle_inputs();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
